mvm_loader: RTL and testbench
=============================

MVM_LOADER -- requirements
Module: mvm_loader

Interface
REQ-001 SHALL have parameter IWIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter NUM_OLANES, default 8, number of MVM output lanes (matrix memory banks).
REQ-003 SHALL have parameter VEC_ADDRW, default 8, vector memory address width.
REQ-004 SHALL have parameter MAT_ADDRW, default 9, matrix memory address width; word width W = 8*IWIDTH.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_go  in  1  begin a load job; sampled only in IDLE.
- i_vec_start_addr  in  VEC_ADDRW  vector base address.
- i_vec_num_words  in  VEC_ADDRW+1  words per vector (N/8).
- i_mat_start_addr  in  MAT_ADDRW  matrix base address.
- i_mat_num_rows_per_olane  in  MAT_ADDRW+1  rows per lane (M/NUM_OLANES).
- i_data  in  W  stream word, 8 elements, element e at bits [e*IWIDTH +: IWIDTH].
- i_valid  in  1  stream word valid.
- o_ready  out  1  loader accepts i_data.
- o_vec_wdata/o_vec_waddr/o_vec_wen  out  W/VEC_ADDRW/1  MVM vector write port.
- o_mat_wdata/o_mat_waddr/o_mat_wen  out  W/MAT_ADDRW/NUM_OLANES  MVM matrix write port, one-hot bank enable.
- o_start  out  1  MVM start pulse.
- o_vec_start_addr, o_vec_num_words, o_mat_start_addr, o_mat_num_rows_per_olane  out  as inputs  job config latched at i_go.
- i_mvm_busy  in  1  MVM o_busy.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse at end of job.

Function
REQ-006 SHALL implement FSM IDLE, LOAD_VEC, LOAD_MAT, ISSUE, WAIT_MVM.
REQ-007 SHALL, in IDLE on i_go=1, latch all config inputs and enter LOAD_VEC; if vec_num_words=0 or mat_num_rows_per_olane=0, instead pulse o_done next cycle, perform no writes, no o_start, stay IDLE.
REQ-008 SHALL assert o_ready only in LOAD_VEC and LOAD_MAT; a word transfers when i_valid&&o_ready.
REQ-009 SHALL, in LOAD_VEC, write transfer w (0-based) to o_vec_waddr = vec_start + w, o_vec_wen=1 exactly one cycle after the transfer cycle (registered outputs, latency 1).
REQ-010 SHALL move to LOAD_MAT after transfer w = vec_num_words-1.
REQ-011 SHALL, in LOAD_MAT, map transfer for row r, word w to lane r mod NUM_OLANES, address mat_start + (r/NUM_OLANES)*vec_num_words + w; o_mat_wen one-hot at that lane, registered, latency 1.
REQ-012 SHALL advance lane after each vec_num_words words; on lane wrap NUM_OLANES-1 -> 0, add vec_num_words to the row-group base.
REQ-013 SHALL leave LOAD_MAT after the last word of row NUM_OLANES*mat_num_rows_per_olane-1; address arithmetic wraps modulo 2^MAT_ADDRW / 2^VEC_ADDRW.
REQ-014 SHALL drive o_vec_wen=0 and o_mat_wen=0 in any cycle with no preceding transfer; wdata/waddr hold last values.
REQ-015 SHALL, in ISSUE, wait while i_mvm_busy=1, then pulse o_start exactly one cycle and enter WAIT_MVM.
REQ-016 SHALL, in WAIT_MVM, wait for i_mvm_busy to rise then fall (or fall when already high), then pulse o_done and enter IDLE.
REQ-017 SHALL ignore i_go outside IDLE and ignore i_data when o_ready=0.
REQ-018 SHALL never assert o_start while the final matrix write is still pending (o_start at least one cycle after last o_mat_wen).

Reset
REQ-019 SHALL, on rst=0 at any time including mid-job, enter IDLE asynchronously, discard partial load, and drive every output to zero.
REQ-020 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Configuration
REQ-021 SHALL honor macro MVM_LOADER_AUTOSTART_EN: defined -> LOAD_MAT goes directly to ISSUE (REQ-015).
REQ-022 SHALL, without MVM_LOADER_AUTOSTART_EN, add input i_start_req (1 bit); after LOAD_MAT hold o_busy=1 with no o_start until i_start_req=1, then proceed as ISSUE.

Verification
REQ-023 vec_start=0, num_words=16, mat_start=0, rows_per_olane=16, 16+2048 words with i_valid stuck high -> 16 vec writes addr 0..15, matrix row 9 word 3 written lane 1 addr 19, single o_start, o_done after MVM busy falls.
REQ-024 Random i_valid gaps (50%) in the REQ-023 job -> identical write sequence, no write without transfer.
REQ-025 num_words=0 with i_go -> o_done next cycle, zero writes, no o_start.
REQ-026 i_mvm_busy held high 20 cycles after load -> o_start deferred until busy low, exactly one pulse.
REQ-027 rst=0 mid LOAD_MAT -> all outputs 0 immediately; new job with vec_start=4, num_words=2, rows_per_olane=1 completes correctly.
REQ-028 i_go pulsed during LOAD_VEC -> ignored, config unchanged.

Source files
------------

// File: rtl/mvm_loader.sv
// Streams one vector, then a lane-interleaved matrix, into the MVM memories and then starts the MVM.
// Writes land one cycle after each transfer. Defining MVM_LOADER_AUTOSTART_EN removes the i_start_req hold.
module mvm_loader #(
  parameter int IWIDTH     = 8,
  parameter int NUM_OLANES = 8,
  parameter int VEC_ADDRW  = 8,
  parameter int MAT_ADDRW  = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_go,
  input  logic [VEC_ADDRW-1:0]    i_vec_start_addr,
  input  logic [VEC_ADDRW:0]      i_vec_num_words,
  input  logic [MAT_ADDRW-1:0]    i_mat_start_addr,
  input  logic [MAT_ADDRW:0]      i_mat_num_rows_per_olane,
  input  logic [8*IWIDTH-1:0]     i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [8*IWIDTH-1:0]     o_vec_wdata,
  output logic [VEC_ADDRW-1:0]    o_vec_waddr,
  output logic                    o_vec_wen,
  output logic [8*IWIDTH-1:0]     o_mat_wdata,
  output logic [MAT_ADDRW-1:0]    o_mat_waddr,
  output logic [NUM_OLANES-1:0]   o_mat_wen,
  output logic                    o_start,
  output logic [VEC_ADDRW-1:0]    o_vec_start_addr,
  output logic [VEC_ADDRW:0]      o_vec_num_words,
  output logic [MAT_ADDRW-1:0]    o_mat_start_addr,
  output logic [MAT_ADDRW:0]      o_mat_num_rows_per_olane,
  input  logic                    i_mvm_busy,
`ifndef MVM_LOADER_AUTOSTART_EN
  input  logic                    i_start_req,
`endif
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int W  = 8*IWIDTH;
  localparam int LW = (NUM_OLANES > 1) ? $clog2(NUM_OLANES) : 1;
  localparam logic [VEC_ADDRW:0] VONE = 1;
  localparam logic [MAT_ADDRW:0] MONE = 1;
  localparam logic [LW-1:0]      LONE = 1;
  localparam logic [LW-1:0]      LMAX = LW'(NUM_OLANES-1);

  typedef enum logic [2:0] {IDLE, LOAD_VEC, LOAD_MAT, WAIT_REQ, ISSUE, WAIT_MVM} state_t;

  state_t                state_q, state_d;
  logic [VEC_ADDRW-1:0]  vec_start_q, vec_start_d;
  logic [VEC_ADDRW:0]    num_words_q, num_words_d;
  logic [MAT_ADDRW-1:0]  mat_start_q, mat_start_d;
  logic [MAT_ADDRW:0]    num_rows_q, num_rows_d;
  logic [VEC_ADDRW:0]    word_q, word_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [MAT_ADDRW:0]    grp_q, grp_d;
  logic [MAT_ADDRW-1:0]  grp_base_q, grp_base_d;
  logic                  busy_seen_q, busy_seen_d;
  logic [W-1:0]          vec_wdata_q, vec_wdata_d;
  logic [VEC_ADDRW-1:0]  vec_waddr_q, vec_waddr_d;
  logic                  vec_wen_q, vec_wen_d;
  logic [W-1:0]          mat_wdata_q, mat_wdata_d;
  logic [MAT_ADDRW-1:0]  mat_waddr_q, mat_waddr_d;
  logic [NUM_OLANES-1:0] mat_wen_q, mat_wen_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;

  logic xfer, last_word, last_lane, last_grp;

  assign o_ready   = (state_q == LOAD_VEC) || (state_q == LOAD_MAT);
  assign xfer      = i_valid && o_ready;
  assign last_word = (word_q == num_words_q - VONE);
  assign last_lane = (lane_q == LMAX);
  assign last_grp  = (grp_q == num_rows_q - MONE);

  always_comb begin
    state_d     = state_q;
    vec_start_d = vec_start_q;
    num_words_d = num_words_q;
    mat_start_d = mat_start_q;
    num_rows_d  = num_rows_q;
    word_d      = word_q;
    lane_d      = lane_q;
    grp_d       = grp_q;
    grp_base_d  = grp_base_q;
    busy_seen_d = busy_seen_q;
    vec_wdata_d = vec_wdata_q;
    vec_waddr_d = vec_waddr_q;
    mat_wdata_d = mat_wdata_q;
    mat_waddr_d = mat_waddr_q;
    vec_wen_d   = 1'b0;
    mat_wen_d   = '0;
    start_d     = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (i_go) begin
        vec_start_d = i_vec_start_addr;
        num_words_d = i_vec_num_words;
        mat_start_d = i_mat_start_addr;
        num_rows_d  = i_mat_num_rows_per_olane;
        word_d      = '0;
        lane_d      = '0;
        grp_d       = '0;
        grp_base_d  = '0;
        // An empty job completes immediately without touching the memories
        if (i_vec_num_words == '0 || i_mat_num_rows_per_olane == '0) done_d = 1'b1;
        else state_d = LOAD_VEC;
      end
      LOAD_VEC: if (xfer) begin
        vec_wdata_d = i_data;
        vec_waddr_d = vec_start_q + word_q[VEC_ADDRW-1:0];
        vec_wen_d   = 1'b1;
        word_d      = word_q + VONE;
        if (last_word) begin
          word_d  = '0;
          state_d = LOAD_MAT;
        end
      end
      LOAD_MAT: if (xfer) begin
        mat_wdata_d         = i_data;
        mat_waddr_d         = mat_start_q + grp_base_q + MAT_ADDRW'(word_q);
        mat_wen_d[lane_q]   = 1'b1;
        word_d              = word_q + VONE;
        if (last_word) begin
          word_d = '0;
          lane_d = lane_q + LONE;
          // Each full sweep across the lanes starts the next row group
          if (last_lane) begin
            lane_d     = '0;
            grp_d      = grp_q + MONE;
            grp_base_d = grp_base_q + MAT_ADDRW'(num_words_q);
            if (last_grp) begin
`ifdef MVM_LOADER_AUTOSTART_EN
              state_d = ISSUE;
`else
              state_d = WAIT_REQ;
`endif
            end
          end
        end
      end
`ifndef MVM_LOADER_AUTOSTART_EN
      WAIT_REQ: if (i_start_req) state_d = ISSUE;
`endif
      ISSUE: if (!i_mvm_busy) begin
        start_d     = 1'b1;
        busy_seen_d = 1'b0;
        state_d     = WAIT_MVM;
      end
      WAIT_MVM: begin
        if (i_mvm_busy) busy_seen_d = 1'b1;
        else if (busy_seen_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      vec_start_q <= '0;
      num_words_q <= '0;
      mat_start_q <= '0;
      num_rows_q  <= '0;
      word_q      <= '0;
      lane_q      <= '0;
      grp_q       <= '0;
      grp_base_q  <= '0;
      busy_seen_q <= 1'b0;
      vec_wdata_q <= '0;
      vec_waddr_q <= '0;
      vec_wen_q   <= 1'b0;
      mat_wdata_q <= '0;
      mat_waddr_q <= '0;
      mat_wen_q   <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_start_q <= vec_start_d;
      num_words_q <= num_words_d;
      mat_start_q <= mat_start_d;
      num_rows_q  <= num_rows_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      grp_q       <= grp_d;
      grp_base_q  <= grp_base_d;
      busy_seen_q <= busy_seen_d;
      vec_wdata_q <= vec_wdata_d;
      vec_waddr_q <= vec_waddr_d;
      vec_wen_q   <= vec_wen_d;
      mat_wdata_q <= mat_wdata_d;
      mat_waddr_q <= mat_waddr_d;
      mat_wen_q   <= mat_wen_d;
      start_q     <= start_d;
      done_q      <= done_d;
    end
  end

  assign o_vec_wdata              = vec_wdata_q;
  assign o_vec_waddr              = vec_waddr_q;
  assign o_vec_wen                = vec_wen_q;
  assign o_mat_wdata              = mat_wdata_q;
  assign o_mat_waddr              = mat_waddr_q;
  assign o_mat_wen                = mat_wen_q;
  assign o_start                  = start_q;
  assign o_done                   = done_q;
  assign o_busy                   = (state_q != IDLE);
  assign o_vec_start_addr         = vec_start_q;
  assign o_vec_num_words          = num_words_q;
  assign o_mat_start_addr         = mat_start_q;
  assign o_mat_num_rows_per_olane = num_rows_q;

endmodule

// File: tb/tb_mvm_loader.sv
// Directed bench for mvm_loader: scoreboard of expected vector/matrix writes checked as the DUT emits them.
module tb_mvm_loader;
  localparam int IW  = 8;
  localparam int NL  = 8;
  localparam int VAW = 8;
  localparam int MAW = 9;
  localparam int W   = 8*IW;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_go;
  logic [VAW-1:0] i_vec_start_addr;
  logic [VAW:0]   i_vec_num_words;
  logic [MAW-1:0] i_mat_start_addr;
  logic [MAW:0]   i_mat_num_rows_per_olane;
  logic [W-1:0]   i_data;
  logic           i_valid;
  logic           o_ready;
  logic [W-1:0]   o_vec_wdata;
  logic [VAW-1:0] o_vec_waddr;
  logic           o_vec_wen;
  logic [W-1:0]   o_mat_wdata;
  logic [MAW-1:0] o_mat_waddr;
  logic [NL-1:0]  o_mat_wen;
  logic           o_start;
  logic [VAW-1:0] o_vec_start_addr;
  logic [VAW:0]   o_vec_num_words;
  logic [MAW-1:0] o_mat_start_addr;
  logic [MAW:0]   o_mat_num_rows_per_olane;
  logic           i_mvm_busy;
  logic           i_start_req;
  logic           o_busy;
  logic           o_done;

  mvm_loader #(.IWIDTH(IW), .NUM_OLANES(NL), .VEC_ADDRW(VAW), .MAT_ADDRW(MAW)) dut (
    .clk(clk), .rst(rst), .i_go(i_go),
    .i_vec_start_addr(i_vec_start_addr), .i_vec_num_words(i_vec_num_words),
    .i_mat_start_addr(i_mat_start_addr), .i_mat_num_rows_per_olane(i_mat_num_rows_per_olane),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_vec_wdata(o_vec_wdata), .o_vec_waddr(o_vec_waddr), .o_vec_wen(o_vec_wen),
    .o_mat_wdata(o_mat_wdata), .o_mat_waddr(o_mat_waddr), .o_mat_wen(o_mat_wen),
    .o_start(o_start),
    .o_vec_start_addr(o_vec_start_addr), .o_vec_num_words(o_vec_num_words),
    .o_mat_start_addr(o_mat_start_addr), .o_mat_num_rows_per_olane(o_mat_num_rows_per_olane),
    .i_mvm_busy(i_mvm_busy), .i_start_req(i_start_req),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [VAW-1:0] addr; logic [W-1:0] data; } vexp_t;
  typedef struct { logic [MAW-1:0] addr; logic [NL-1:0] wen; logic [W-1:0] data; int r; int w; } mexp_t;

  vexp_t vq[$];
  mexp_t mq[$];
  vexp_t mon_v;
  mexp_t mon_m;
  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int cfg_vs, cfg_nw, cfg_ms, cfg_rpo;
  logic [MAW-1:0] cap_addr;
  logic [NL-1:0]  cap_wen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every write the DUT emits must match the oldest expected transfer.
  always @(negedge clk) begin
    if (rst) begin
      if (o_vec_wen) begin
        if (vq.size() == 0) check("vec_write_without_transfer", 64'(1), 64'(0));
        else begin
          mon_v = vq.pop_front();
          check("vec_waddr", 64'(o_vec_waddr), 64'(mon_v.addr));
          check("vec_wdata", o_vec_wdata, mon_v.data);
        end
      end
      if (o_mat_wen != '0) begin
        if (mq.size() == 0) check("mat_write_without_transfer", 64'(o_mat_wen), 64'(0));
        else begin
          mon_m = mq.pop_front();
          check("mat_wen", 64'(o_mat_wen), 64'(mon_m.wen));
          check("mat_waddr", 64'(o_mat_waddr), 64'(mon_m.addr));
          check("mat_wdata", o_mat_wdata, mon_m.data);
          if (mon_m.r == 9 && mon_m.w == 3) begin
            cap_addr = o_mat_waddr;
            cap_wen  = o_mat_wen;
          end
        end
      end
      if (o_start) begin
        start_cnt++;
        check("start_with_mat_write", 64'(o_mat_wen), 64'(0));
        check("start_with_mat_pending", 64'(mq.size()), 64'(0));
      end
      if (o_done) done_cnt++;
    end
  end

  task automatic send_word(input logic [W-1:0] d, input bit gap);
    int n;
    bit ok;
    if (gap && $urandom_range(1, 0) == 1) begin
      i_valid = 1'b0;
      repeat ($urandom_range(3, 1)) begin
        i_data = {$urandom, $urandom};
        @(posedge clk); #1;
      end
    end
    i_data  = d;
    i_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      ok = o_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) check("transfer_timeout", 64'(0), 64'(1));
  endtask

  task automatic start_job(input int vs, input int nw, input int ms, input int rpo);
    cfg_vs = vs; cfg_nw = nw; cfg_ms = ms; cfg_rpo = rpo;
    start_cnt = 0;
    done_cnt  = 0;
    i_vec_start_addr         = VAW'(vs);
    i_vec_num_words          = (VAW+1)'(nw);
    i_mat_start_addr         = MAW'(ms);
    i_mat_num_rows_per_olane = (MAW+1)'(rpo);
    i_go = 1'b1;
    @(posedge clk); #1;
    i_go = 1'b0;
  endtask

  task automatic load_vec(input bit gap, input bit glitch);
    vexp_t e;
    for (int w = 0; w < cfg_nw; w++) begin
      e.addr = VAW'(cfg_vs + w);
      e.data = {$urandom, $urandom};
      vq.push_back(e);
      if (glitch && w == 1) begin
        i_go = 1'b1;
        i_vec_start_addr = ~i_vec_start_addr;
        i_vec_num_words = 1;
        i_mat_start_addr = ~i_mat_start_addr;
        i_mat_num_rows_per_olane = 1;
      end
      send_word(e.data, gap);
      i_go = 1'b0;
    end
  endtask

  task automatic load_mat(input bit gap, input int max_rows);
    mexp_t m;
    int rows;
    rows = (NL*cfg_rpo < max_rows) ? NL*cfg_rpo : max_rows;
    for (int r = 0; r < rows; r++) begin
      for (int w = 0; w < cfg_nw; w++) begin
        m.addr = MAW'(cfg_ms + (r/NL)*cfg_nw + w);
        m.wen = '0;
        m.wen[r % NL] = 1'b1;
        m.data = {$urandom, $urandom};
        m.r = r;
        m.w = w;
        mq.push_back(m);
        send_word(m.data, gap);
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic finish_job(input int hold);
    int n;
    repeat (3) begin @(posedge clk); #1; end
    check("no_start_before_req", 64'(start_cnt), 64'(0));
    check("busy_waiting_req", 64'(o_busy), 64'(1));
    i_start_req = 1'b1;
    @(posedge clk); #1;
    i_start_req = 1'b0;
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      check("start_deferred_by_busy", 64'(start_cnt), 64'(0));
      i_mvm_busy = 1'b0;
    end
    n = 0;
    while (start_cnt == 0 && n < 50) begin @(posedge clk); #1; n++; end
    check("start_seen", 64'(start_cnt), 64'(1));
    i_mvm_busy = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("no_done_while_mvm_busy", 64'(done_cnt), 64'(0));
    i_mvm_busy = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 50) begin @(posedge clk); #1; n++; end
    repeat (2) begin @(posedge clk); #1; end
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("start_pulses", 64'(start_cnt), 64'(1));
    check("idle_after_done", 64'(o_busy), 64'(0));
    check("vec_queue_drained", 64'(vq.size()), 64'(0));
    check("mat_queue_drained", 64'(mq.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b0; i_go = 1'b0; i_valid = 1'b0; i_data = '0;
    i_vec_start_addr = '0; i_vec_num_words = '0;
    i_mat_start_addr = '0; i_mat_num_rows_per_olane = '0;
    i_mvm_busy = 1'b0; i_start_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({o_ready, o_vec_wen, o_mat_wen, o_start, o_busy, o_done}), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Full-size job with valid held high
    cap_addr = '0; cap_wen = '0;
    start_job(0, 16, 0, 16);
    check("job_a_busy", 64'(o_busy), 64'(1));
    check("job_a_ready", 64'(o_ready), 64'(1));
    check("job_a_cfg_nw", 64'(o_vec_num_words), 64'(16));
    check("job_a_cfg_rpo", 64'(o_mat_num_rows_per_olane), 64'(16));
    load_vec(1'b0, 1'b0);
    load_mat(1'b0, 1 << 30);
    finish_job(0);
    check("r9w3_addr", 64'(cap_addr), 64'(19));
    check("r9w3_lane", 64'(cap_wen), 64'(8'h02));

    // Same job with random valid gaps
    cap_addr = '0; cap_wen = '0;
    start_job(0, 16, 0, 16);
    load_vec(1'b1, 1'b0);
    load_mat(1'b1, 1 << 30);
    finish_job(0);
    check("gap_r9w3_addr", 64'(cap_addr), 64'(19));

    // Empty jobs finish at once
    start_job(3, 0, 5, 4);
    check("zero_words_done", 64'(o_done), 64'(1));
    check("zero_words_idle", 64'(o_busy), 64'(0));
    repeat (3) begin @(posedge clk); #1; end
    check("zero_words_done_once", 64'(done_cnt), 64'(1));
    check("zero_words_no_start", 64'(start_cnt), 64'(0));
    start_job(3, 4, 5, 0);
    check("zero_rows_done", 64'(o_done), 64'(1));
    check("zero_rows_no_ready", 64'(o_ready), 64'(0));
    repeat (3) begin @(posedge clk); #1; end

    // Busy MVM, i_go glitch during vector load, address wrap on both memories
    i_mvm_busy = 1'b1;
    start_job(250, 8, 510, 2);
    load_vec(1'b0, 1'b1);
    check("glitch_cfg_vs", 64'(o_vec_start_addr), 64'(250));
    check("glitch_cfg_nw", 64'(o_vec_num_words), 64'(8));
    check("glitch_cfg_ms", 64'(o_mat_start_addr), 64'(510));
    check("glitch_cfg_rpo", 64'(o_mat_num_rows_per_olane), 64'(2));
    load_mat(1'b1, 1 << 30);
    finish_job(20);

    // Reset in the middle of the matrix load
    start_job(0, 16, 0, 16);
    load_vec(1'b0, 1'b0);
    load_mat(1'b0, 3);
    #2 rst = 1'b0;
    #1;
    check("midrst_ctrl", 64'({o_ready, o_vec_wen, o_mat_wen, o_start, o_busy, o_done}), 64'(0));
    check("midrst_vec_wdata", o_vec_wdata, 64'(0));
    check("midrst_mat_wdata", o_mat_wdata, 64'(0));
    check("midrst_addrs", 64'({o_vec_waddr, o_mat_waddr}), 64'(0));
    check("midrst_cfg", 64'({o_vec_start_addr, o_vec_num_words, o_mat_start_addr, o_mat_num_rows_per_olane}), 64'(0));
    vq.delete();
    mq.delete();
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    start_job(4, 2, 7, 1);
    load_vec(1'b0, 1'b0);
    load_mat(1'b0, 1 << 30);
    finish_job(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
